// File: rtl/hypercpu_regwrite_arbiter.sv
// Round-robin arbiter funnelling several register-write requesters into a
// single registered write port. State updates on the falling edge of mclk.
// Writes to the stack-pointer and program-counter registers also raise a
// dedicated pulse that is aligned with write_enable.

module hypercpu_regwrite_arbiter #(
  parameter int  NUM_REQ    = 3,
  parameter int  REG_COUNT  = 16,
  parameter int  SP_ADDR    = REG_COUNT - 2,
  parameter int  PC_ADDR    = REG_COUNT - 1,
  localparam int REG_BITS   = $clog2(REG_COUNT),
  localparam int GRANT_BITS = $clog2(NUM_REQ)
) (
  input  logic                         mclk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*REG_BITS-1:0]  req_addr,
  input  logic [NUM_REQ*32-1:0]        req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         hold,
  output logic                         write_enable,
  output logic [REG_BITS-1:0]          write_addr,
  output logic [31:0]                  write_data,
  output logic                         sp_written,
  output logic                         pc_written,
  output logic [GRANT_BITS-1:0]        last_grant
);

  logic                  grant_found;
  logic [GRANT_BITS-1:0] grant_idx;
  logic                  transfer;
  logic [REG_BITS-1:0]   sel_addr;
  logic [31:0]           sel_data;

  // Search upward from the requester after the last winner, wrapping around;
  // the first valid requester wins. hold suppresses the grant but not the search.
  always_comb begin
    int                  cand;
    logic [GRANT_BITS-1:0] cand_idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = (int'(last_grant) + k) % NUM_REQ;
      cand_idx = GRANT_BITS'(cand);
      if (!grant_found && req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  // One-hot ready towards the winning requester, zero while frozen.
  always_comb begin
    req_ready = '0;
    if (grant_found && !hold) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign transfer = |(req_ready & req_valid);

  // Mux the winner's address and data; addresses are passed through untouched.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == GRANT_BITS'(i)) begin
        sel_addr = req_addr[i*REG_BITS +: REG_BITS];
        sel_data = req_data[i*32 +: 32];
      end
    end
  end

  // Register the granted write; address/data hold when nothing transfers.
  // Reset restarts the rotation so the first search begins at requester 0.
  always_ff @(negedge mclk or negedge reset) begin
    if (!reset) begin
      write_enable <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
      sp_written   <= 1'b0;
      pc_written   <= 1'b0;
      last_grant   <= GRANT_BITS'(NUM_REQ - 1);
    end else begin
      write_enable <= transfer;
      sp_written   <= transfer && (sel_addr == REG_BITS'(SP_ADDR));
      pc_written   <= transfer && (sel_addr == REG_BITS'(PC_ADDR));
      if (transfer) begin
        write_addr <= sel_addr;
        write_data <= sel_data;
        last_grant <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_hypercpu_regwrite_arbiter.sv
// Directed bench for hypercpu_regwrite_arbiter with a write scoreboard.
// Inputs change just after posedge mclk; the DUT acts on negedge; outputs
// are sampled 1 ns after the following posedge.

module tb_hypercpu_regwrite_arbiter;

  typedef struct packed {
    logic        we;
    logic [3:0]  addr;
    logic [31:0] data;
    logic        sp;
    logic        pc;
  } exp_t;

  logic         mclk;
  logic         reset;
  logic [2:0]   req_valid;
  logic [11:0]  req_addr;
  logic [95:0]  req_data;
  logic [2:0]   req_ready;
  logic         hold;
  logic         write_enable;
  logic [3:0]   write_addr;
  logic [31:0]  write_data;
  logic         sp_written;
  logic         pc_written;
  logic [1:0]   last_grant;

  logic [3:0]   a [3];
  logic [31:0]  d [3];
  exp_t         sb_q [$];
  logic [1:0]   exp_last;
  logic [3:0]   held_addr;
  logic [31:0]  held_data;
  logic [31:0]  regs [16];
  int           n_vec;
  int           n_err;

  hypercpu_regwrite_arbiter dut (
    .mclk         (mclk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .hold         (hold),
    .write_enable (write_enable),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .sp_written   (sp_written),
    .pc_written   (pc_written),
    .last_grant   (last_grant)
  );

  initial mclk = 1'b1;
  always #5 mclk = ~mclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Clear the bench model to its post-reset state.
  task automatic model_reset();
    sb_q.delete();
    exp_last  = 2'd2;
    held_addr = '0;
    held_data = '0;
  endtask

  // One clock: apply inputs, check ready, predict the write, check outputs.
  task automatic cycle(input logic [2:0] valid, input logic hld, input logic [2:0] exp_ready);
    exp_t e;
    int   g;
    req_valid = valid;
    hold      = hld;
    req_addr  = {a[2], a[1], a[0]};
    req_data  = {d[2], d[1], d[0]};
    #1;
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    g = -1;
    for (int i = 0; i < 3; i++) if (exp_ready[i]) g = i;
    if (g >= 0) begin
      held_addr = a[g];
      held_data = d[g];
      exp_last  = 2'(g);
      e = '{we: 1'b1, addr: a[g], data: d[g], sp: (a[g] == 4'd14), pc: (a[g] == 4'd15)};
    end else begin
      e = '{we: 1'b0, addr: held_addr, data: held_data, sp: 1'b0, pc: 1'b0};
    end
    sb_q.push_back(e);
    @(negedge mclk);
    @(posedge mclk);
    #1;
    if (write_enable === 1'b1) regs[write_addr] = write_data;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 64'(1), 64'(0));
    end else begin
      e = sb_q.pop_front();
      chk("write_enable", 64'(write_enable), 64'(e.we));
      chk("write_addr",   64'(write_addr),   64'(e.addr));
      chk("write_data",   64'(write_data),   64'(e.data));
      chk("sp_written",   64'(sp_written),   64'(e.sp));
      chk("pc_written",   64'(pc_written),   64'(e.pc));
    end
    chk("last_grant", 64'(last_grant), 64'(exp_last));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_we"},   64'(write_enable), 64'(0));
    chk({tag, "_addr"}, 64'(write_addr),   64'(0));
    chk({tag, "_data"}, 64'(write_data),   64'(0));
    chk({tag, "_sp"},   64'(sp_written),   64'(0));
    chk({tag, "_pc"},   64'(pc_written),   64'(0));
    chk({tag, "_last"}, 64'(last_grant),   64'(2));
  endtask

  // Asynchronous reset pulse between clock edges.
  task automatic reset_pulse(input string tag);
    reset = 1'b0;
    #1;
    chk_reset_outputs(tag);
    model_reset();
    reset = 1'b1;
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    hold  = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    for (int i = 0; i < 3; i++) begin a[i] = '0; d[i] = '0; end
    for (int i = 0; i < 16; i++) regs[i] = '0;
    model_reset();

    // Reset state
    repeat (2) @(posedge mclk);
    #1;
    chk_reset_outputs("rst");
    chk("rst_ready", 64'(req_ready), 64'(0));
    reset = 1'b1;

    // Single request
    a[0] = 4'd3; d[0] = 32'hDEAD_BEEF;
    cycle(3'b001, 1'b0, 3'b001);
    cycle(3'b000, 1'b0, 3'b000);
    cycle(3'b000, 1'b0, 3'b000);

    // All-valid contention from reset: 0,1,2,0,1,2 back to back
    reset_pulse("rst2");
    a[0] = 4'd1; d[0] = 32'h1111_0000;
    a[1] = 4'd2; d[1] = 32'h2222_0000;
    a[2] = 4'd6; d[2] = 32'h3333_0000;
    repeat (2) begin
      cycle(3'b111, 1'b0, 3'b001);
      cycle(3'b111, 1'b0, 3'b010);
      cycle(3'b111, 1'b0, 3'b100);
    end
    cycle(3'b000, 1'b0, 3'b000);

    // Hold blocks grants, then req 1 then req 2
    a[1] = 4'd7; d[1] = 32'hA1A1_A1A1;
    a[2] = 4'd8; d[2] = 32'hB2B2_B2B2;
    repeat (3) cycle(3'b110, 1'b1, 3'b000);
    cycle(3'b110, 1'b0, 3'b010);
    cycle(3'b100, 1'b0, 3'b100);
    cycle(3'b000, 1'b0, 3'b000);

    // Hold rising right after a grant does not cancel that write
    a[0] = 4'd9; d[0] = 32'h0BAD_F00D;
    cycle(3'b001, 1'b0, 3'b001);
    cycle(3'b001, 1'b1, 3'b000);
    cycle(3'b000, 1'b0, 3'b000);

    // Special registers: PC, then SP, then ordinary
    a[0] = 4'd15; d[0] = 32'h0000_0F0F;
    cycle(3'b001, 1'b0, 3'b001);
    a[0] = 4'd14; d[0] = 32'h0000_0E0E;
    cycle(3'b001, 1'b0, 3'b001);
    a[0] = 4'd5;  d[0] = 32'h0000_0505;
    cycle(3'b001, 1'b0, 3'b001);
    cycle(3'b000, 1'b0, 3'b000);

    // Reset while write_enable is high, then req 2 wins first
    a[1] = 4'd10; d[1] = 32'hCAFE_0001;
    cycle(3'b010, 1'b0, 3'b010);
    chk("pre_rst_we", 64'(write_enable), 64'(1));
    reset_pulse("rst_mid");
    a[2] = 4'd11; d[2] = 32'hCAFE_0002;
    cycle(3'b100, 1'b0, 3'b100);
    cycle(3'b000, 1'b0, 3'b000);

    // Same-address race: 0x1 then 0x2 to register 4
    reset_pulse("rst3");
    a[0] = 4'd4; d[0] = 32'h1;
    a[1] = 4'd4; d[1] = 32'h2;
    cycle(3'b011, 1'b0, 3'b001);
    cycle(3'b010, 1'b0, 3'b010);
    cycle(3'b000, 1'b0, 3'b000);
    chk("race_final_reg4", 64'(regs[4]), 64'(32'h2));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hypercpu_regwrite_arbiter.md
HYPERCPU_REGWRITE_ARBITER -- requirements
Module: hypercpu_regwrite_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3: number of write requesters, 2..8.
REQ-002 Parameter REG_COUNT, default 16: register count; REG_BITS = $clog2(REG_COUNT).
REQ-003 Parameters SP_ADDR, default REG_COUNT-2, and PC_ADDR, default REG_COUNT-1: special register addresses.
REQ-004 mclk  input  1  sole clock; all state SHALL update on negedge mclk.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  NUM_REQ  per-requester write request.
REQ-007 req_addr  input  NUM_REQ x REG_BITS  per-requester target register.
REQ-008 req_data  input  NUM_REQ x 32  per-requester write data.
REQ-009 req_ready  output  NUM_REQ  per-requester grant; one-hot or zero.
REQ-010 hold  input  1  pipeline freeze; high blocks all new grants.
REQ-011 write_enable  output  1  registered write strobe to the register file.
REQ-012 write_addr  output  REG_BITS  registered write address.
REQ-013 write_data  output  32  registered write data.
REQ-014 sp_written / pc_written  output  1 each  registered pulses, high when write_addr equals SP_ADDR / PC_ADDR while write_enable is high.
REQ-015 last_grant  output  $clog2(NUM_REQ)  index of the most recently granted requester.

Function
REQ-016 A transfer SHALL occur on a negedge where req_valid[i] and req_ready[i] are both high.
REQ-017 req_ready SHALL be combinational from req_valid, hold and the rotate pointer. It SHALL have at most one bit set, and SHALL be all-zero when hold is high or no req_valid bit is set.
REQ-018 Arbitration SHALL be round-robin. The search starts at index (last_grant+1) mod NUM_REQ and proceeds upward with wrap. The first valid index wins.
REQ-019 On a transfer, last_grant SHALL be updated to the granted index. Without a transfer, last_grant SHALL hold.
REQ-020 On a transfer, the granted req_addr/req_data SHALL be registered to write_addr/write_data, and write_enable SHALL be 1 for exactly the following cycle. Latency is one mclk negedge.
REQ-021 With no transfer, write_enable SHALL be 0 and write_addr/write_data SHALL hold their previous values.
REQ-022 Back-to-back transfers SHALL be supported: one transfer per cycle, and write_enable may stay high continuously.
REQ-023 sp_written/pc_written SHALL be registered in the same edge as write_enable, from the granted req_addr.
REQ-024 A requester SHALL hold req_valid, req_addr and req_data stable until granted. The arbiter SHALL NOT drop or reorder a single requester's writes.
REQ-025 Starvation bound: a continuously valid requester SHALL be granted within NUM_REQ cycles of hold going low.
REQ-026 Same-address requests from different requesters in consecutive cycles SHALL both be written, in grant order; last grant wins.
REQ-027 hold asserting SHALL NOT cancel a write already registered; that write_enable pulse SHALL still complete.
REQ-028 Unused req_addr values of REG_COUNT or greater cannot occur for a power-of-two REG_COUNT. Otherwise they SHALL be passed through unmodified.

Reset
REQ-029 While reset is low: write_enable, sp_written, pc_written, write_addr and write_data SHALL be 0, and last_grant SHALL be NUM_REQ-1, so the first search starts at index 0.
REQ-030 Reset assertion mid-transfer SHALL immediately force write_enable to 0. The pending write is discarded, and the requester is not considered granted.
REQ-031 On reset deassertion, the first grant SHALL occur on the first negedge with a valid request and hold low.

Verification
REQ-032 Single request: req_valid=001, addr 3, data 0xDEADBEEF -> req_ready=001 in the same cycle; next cycle write_enable=1, write_addr=3, write_data=0xDEADBEEF; the cycle after, write_enable=0.
REQ-033 All-valid contention: req_valid=111 held 6 cycles from reset -> grant sequence 0,1,2,0,1,2 with write_enable high all 6 following cycles.
REQ-034 Hold: req_valid=110, hold=1 for 3 cycles -> req_ready=000 and write_enable=0; hold drops -> req 1 granted, then req 2.
REQ-035 Special registers: grant addr 15, then addr 14, then addr 5 -> pc_written=1, then sp_written=1, then neither, each aligned with write_enable.
REQ-036 Reset mid-operation: assert reset while write_enable=1 -> outputs 0 asynchronously; after release with req_valid=100 -> req 2 granted first, last_grant=2.
REQ-037 Same-address race: req0 addr 4 data 0x1, req1 addr 4 data 0x2, both valid -> writes 0x1 then 0x2 on consecutive cycles; final register value 0x2.
